keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
- Parametrised matrix-keypad scanner and event generator; successor to the fixed 3x4 scan logic in the game top level.
- Drives one-hot active-high columns and samples active-high rows.
- Debounces both press and release and rejects multi-key chords.
- Delivers each accepted key press as a code with a valid/ack handshake and a sticky overflow flag, for consumption by the game FSM and the menu logic.

Parameters:
CLK_DIV, 12500, clk cycles per scan tick (>=2)
N_COLS, 3, keypad columns (>=2)
N_ROWS, 4, keypad rows (>=1)
DEBOUNCE, 4, consecutive matching ticks needed to accept a press or a release (>=2)
CODE_W, 4, key_code width; must be >= clog2(N_ROWS*N_COLS)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, asynchronous, active-low
key_row  in  N_ROWS  row sense lines, active-high
key_col  out  N_COLS  column drive, one-hot, active-high
key_code  out  CODE_W  code of last accepted press = row_idx*N_COLS + col_idx (0-based)
key_valid  out  1  press event pending; held until acknowledged
key_ack  in  1  consumer acknowledge; consumed when key_valid=1
key_down  out  1  high while a debounced key is held
key_ovf  out  1  sticky: a press was accepted while key_valid was still pending

Behaviour:
- Reset (rst=0, async) values:
  - divider=0, tick=0, state=SCAN, col_idx=0, key_col=1 (col 0 driven).
  - key_code=0, key_valid=0, key_down=0, key_ovf=0, all counters 0.
- Tick: a 1-cycle internal strobe when the divider reaches CLK_DIV-1; the divider then wraps to 0. The divider is free-running in every state.
- All FSM actions happen only on tick cycles. key_row is sampled on the tick, before any column change.
- Row classification per sample:
  - ZERO: all bits 0.
  - ONE: exactly one bit set.
  - MULTI: two or more bits set.
- SCAN:
  - ZERO: col_idx advances, N_COLS-1 wraps to 0.
  - ONE: latch row one-hot and col_idx; cnt=1; go to DEBOUNCE. Column does not advance.
  - MULTI: stay in SCAN on the same column, no event (chord rejection).
- DEBOUNCE:
  - Sample equals the latched one-hot: cnt+1. When cnt reaches DEBOUNCE, go to PRESSED and fire the press event.
  - Any other sample: return to SCAN, column unchanged, cnt=0.
- PRESSED:
  - key_down=1.
  - ZERO: rel_cnt+1. When rel_cnt reaches DEBOUNCE, go to SCAN, advance the column, key_down=0.
  - Any non-ZERO sample: rel_cnt=0, stay in PRESSED. A second key added while held is ignored.
- Press event:
  - Fires in the clock cycle after the DEBOUNCE-th matching tick, so latency is DEBOUNCE ticks from the first detecting tick.
  - If key_valid=0, or key_ack=1 in the same cycle: key_code=row_idx*N_COLS+col_idx, key_valid=1.
  - Otherwise: key_code and key_valid are unchanged and key_ovf=1.
- Handshake:
  - key_ack while key_valid=1 clears key_valid in the next cycle.
  - key_ack while key_valid=0 is ignored.
  - Simultaneous ack and new event: the new code is loaded and key_valid stays 1.
- key_ovf is cleared only by reset.
- key_code holds its value after ack.
- Reset mid-operation:
  - Immediate return to reset values, including during DEBOUNCE or PRESSED.
  - A key still held after reset is re-detected from SCAN and produces a fresh event after DEBOUNCE ticks.
- Widths:
  - col_idx and row_idx are clog2-sized.
  - cnt and rel_cnt are sized to hold DEBOUNCE.
  - key_code is computed at CODE_W bits, zero-extended.

Test Plan:
- Reset and idle scan (CLK_DIV=4, defaults otherwise), key_row=0 after release of rst → key_col cycles 001,010,100,001 changing every 4 clk; all outputs 0.
- Press at row1/col2 (key_row=0010 while key_col=100) held stable → no column advance; key_valid rises 1 cycle after the 4th matching tick; key_code=5; key_down=1. Ack → key_valid=0.
- Bounce: key_row toggles 0010/0000 on alternate ticks → no event. Then stable for 4 ticks → exactly one event. Release bouncing → key_down stays 1 until 4 consecutive ZERO ticks.
- Chord: key_row=0011 on col 0 → no event; column frozen while chord is present; scanning resumes on release.
- Overflow: two distinct presses (codes 0 then 4) with no ack → key_code=0, key_valid=1, key_ovf=1. Second pair with ack asserted in the event cycle → key_code=new code, key_ovf unchanged.
- Async reset asserted mid-DEBOUNCE and mid-PRESSED → outputs cleared within the reset assertion, not waiting for a clock edge. Key held through release of rst → new event after DEBOUNCE ticks.
- Parametrised config N_COLS=4, N_ROWS=4, CODE_W=4: press row3/col3 → key_code=15; key_col wraps 0001→1000→0001.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner. Drives one-hot columns, debounces press and release,
// rejects chords, and queues one press event with valid/ack and sticky overflow.
module keypad_scan_ctrl #(
    parameter int CLK_DIV  = 12500,
    parameter int N_COLS   = 3,
    parameter int N_ROWS   = 4,
    parameter int DEBOUNCE = 4,
    parameter int CODE_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_ROWS-1:0] key_row,
    output logic [N_COLS-1:0] key_col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ack,
    output logic              key_down,
    output logic              key_ovf
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int COL_W = $clog2(N_COLS);
    localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED} state_t;

    logic [DIV_W-1:0]  r_div;
    logic              w_tick;
    state_t            r_state, w_state_nxt;
    logic [COL_W-1:0]  r_col_idx, w_col_nxt, w_col_adv;
    logic [N_ROWS-1:0] r_row_oh, w_row_oh_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [CNT_W-1:0]  r_rel_cnt, w_rel_nxt, w_rel_inc;
    logic              r_fire, w_fire_nxt;
    logic [ROW_W-1:0]  w_row_idx;
    logic [CODE_W-1:0] w_code;
    logic              w_zero, w_one;
    logic [CODE_W-1:0] r_key_code;
    logic              r_key_valid, r_key_ovf;

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_zero    = (key_row == '0);
    assign w_one     = !w_zero && ((key_row & (key_row - 1'b1)) == '0);
    assign w_col_adv = (r_col_idx == COL_W'(N_COLS - 1)) ? '0 : r_col_idx + 1'b1;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_rel_inc = r_rel_cnt + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_col_nxt    = r_col_idx;
        w_row_oh_nxt = r_row_oh;
        w_cnt_nxt    = r_cnt;
        w_rel_nxt    = r_rel_cnt;
        w_fire_nxt   = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_SCAN: begin
                    if (w_zero) begin
                        w_col_nxt = w_col_adv;
                    end else if (w_one) begin
                        w_row_oh_nxt = key_row;
                        w_cnt_nxt    = CNT_W'(1);
                        w_state_nxt  = S_DEBOUNCE;
                    end
                    // chords leave the scan parked on this column
                end
                S_DEBOUNCE: begin
                    if (key_row == r_row_oh) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_W'(DEBOUNCE)) begin
                            w_state_nxt = S_PRESSED;
                            w_fire_nxt  = 1'b1;
                            w_cnt_nxt   = '0;
                            w_rel_nxt   = '0;
                        end
                    end else begin
                        w_state_nxt = S_SCAN;
                        w_cnt_nxt   = '0;
                    end
                end
                S_PRESSED: begin
                    if (w_zero) begin
                        w_rel_nxt = w_rel_inc;
                        if (w_rel_inc == CNT_W'(DEBOUNCE)) begin
                            w_state_nxt = S_SCAN;
                            w_col_nxt   = w_col_adv;
                            w_rel_nxt   = '0;
                        end
                    end else begin
                        w_rel_nxt = '0;
                    end
                end
                default: w_state_nxt = S_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_SCAN;
            r_col_idx <= '0;
            r_row_oh  <= '0;
            r_cnt     <= '0;
            r_rel_cnt <= '0;
            r_fire    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_col_idx <= w_col_nxt;
            r_row_oh  <= w_row_oh_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rel_cnt <= w_rel_nxt;
            r_fire    <= w_fire_nxt;
        end
    end

    always_comb begin
        w_row_idx = '0;
        for (int i = 0; i < N_ROWS; i++) begin
            if (r_row_oh[i]) w_row_idx = ROW_W'(i);
        end
    end

    // row/col stay frozen while PRESSED, so the code is valid in the event cycle
    assign w_code = CODE_W'(w_row_idx) * CODE_W'(N_COLS) + CODE_W'(r_col_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_ovf   <= 1'b0;
        end else if (r_fire) begin
            if (!r_key_valid || key_ack) begin
                r_key_code  <= w_code;
                r_key_valid <= 1'b1;
            end else begin
                r_key_ovf <= 1'b1;
            end
        end else if (key_ack) begin
            r_key_valid <= 1'b0;
        end
    end

    assign key_col   = {{(N_COLS-1){1'b0}}, 1'b1} << r_col_idx;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_ovf   = r_key_ovf;
    assign key_down  = (r_state == S_PRESSED);
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: two instances (3x4 and 4x4) driven one sample per
// scan tick, compared against a tick-level behavioural model of the keypad rules.
module tb_keypad_scan_ctrl;
    localparam int DEB = 4;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [3:0] row0 = 4'b0;
    logic [3:0] row1 = 4'b0;
    logic       ack0 = 1'b0;
    logic       ack1 = 1'b0;
    logic [2:0] col0;
    logic [3:0] col1;
    logic [3:0] code0, code1;
    logic       vld0, vld1, down0, down1, ovf0, ovf1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.CLK_DIV(4), .N_COLS(3), .N_ROWS(4), .DEBOUNCE(DEB), .CODE_W(4)) u_kp3 (
        .clk(clk), .rst(rst), .key_row(row0), .key_col(col0), .key_code(code0),
        .key_valid(vld0), .key_ack(ack0), .key_down(down0), .key_ovf(ovf0)
    );

    keypad_scan_ctrl #(.CLK_DIV(4), .N_COLS(4), .N_ROWS(4), .DEBOUNCE(DEB), .CODE_W(4)) u_kp4 (
        .clk(clk), .rst(rst), .key_row(row1), .key_col(col1), .key_code(code1),
        .key_valid(vld1), .key_ack(ack1), .key_down(down1), .key_ovf(ovf1)
    );

    // Reference model: one entry per instance, advanced once per scan tick.
    int         ncols[2] = '{3, 4};
    int         m_col[2], m_cand[2], m_run[2], m_held[2], m_zrun[2];
    int         m_valid[2], m_code[2], m_ovf[2], ev[2], ev_code[2];
    logic [3:0] m_cand_row[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_col[d] = 0; m_cand[d] = -1; m_run[d] = 0; m_held[d] = 0; m_zrun[d] = 0;
            m_valid[d] = 0; m_code[d] = 0; m_ovf[d] = 0; ev[d] = 0; ev_code[d] = 0;
            m_cand_row[d] = 4'b0;
        end
    endtask

    task automatic model_tick(input int d, input logic [3:0] s);
        int p = $countones(s);
        int r = 0;
        ev[d] = 0;
        for (int i = 0; i < 4; i++) if (s[i]) r = i;
        if (m_held[d] != 0) begin
            if (s == 4'b0) begin
                m_zrun[d]++;
                if (m_zrun[d] == DEB) begin
                    m_held[d] = 0;
                    m_zrun[d] = 0;
                    m_col[d]  = (m_col[d] + 1) % ncols[d];
                end
            end else begin
                m_zrun[d] = 0;
            end
        end else if (m_cand[d] >= 0) begin
            if (s == m_cand_row[d]) begin
                m_run[d]++;
                if (m_run[d] == DEB) begin
                    m_held[d]  = 1;
                    m_zrun[d]  = 0;
                    ev[d]      = 1;
                    ev_code[d] = m_cand[d];
                    m_cand[d]  = -1;
                    m_run[d]   = 0;
                end
            end else begin
                m_cand[d] = -1;
                m_run[d]  = 0;
            end
        end else if (p == 0) begin
            m_col[d] = (m_col[d] + 1) % ncols[d];
        end else if (p == 1) begin
            m_cand[d]     = r * ncols[d] + m_col[d];
            m_cand_row[d] = s;
            m_run[d]      = 1;
        end
    endtask

    task automatic model_resolve(input int d, input bit late_ack);
        if (ev[d] != 0) begin
            if (m_valid[d] == 0 || late_ack) begin
                m_valid[d] = 1;
                m_code[d]  = ev_code[d];
            end else begin
                m_ovf[d] = 1;
            end
        end else if (late_ack && m_valid[d] != 0) begin
            m_valid[d] = 0;
        end
    endtask

    task automatic check_outs(input string ph);
        check($sformatf("%s kp3 col", ph),   32'({1'b0, col0}), 32'(1) << m_col[0]);
        check($sformatf("%s kp3 valid", ph), 32'(vld0),  m_valid[0]);
        check($sformatf("%s kp3 code", ph),  32'(code0), m_code[0]);
        check($sformatf("%s kp3 down", ph),  32'(down0), m_held[0]);
        check($sformatf("%s kp3 ovf", ph),   32'(ovf0),  m_ovf[0]);
        check($sformatf("%s kp4 col", ph),   32'(col1),  32'(1) << m_col[1]);
        check($sformatf("%s kp4 valid", ph), 32'(vld1),  m_valid[1]);
        check($sformatf("%s kp4 code", ph),  32'(code1), m_code[1]);
        check($sformatf("%s kp4 down", ph),  32'(down1), m_held[1]);
        check($sformatf("%s kp4 ovf", ph),   32'(ovf1),  m_ovf[1]);
    endtask

    // One scan tick. Entered 1ns after the 2nd clock of a tick period; the
    // tick edge is the 2nd clock below, the event cycle follows it.
    task automatic step(input logic [3:0] r0, input logic [3:0] r1,
                        input logic [1:0] ea, input logic [1:0] la);
        row0 = r0; row1 = r1;
        ack0 = ea[0]; ack1 = ea[1];
        for (int d = 0; d < 2; d++) if (ea[d] && m_valid[d] != 0) m_valid[d] = 0;
        model_tick(0, r0);
        model_tick(1, r1);
        @(posedge clk); #1;
        ack0 = 1'b0; ack1 = 1'b0;
        @(posedge clk); #1;
        check("kp3 valid before event", 32'(vld0), m_valid[0]);
        check("kp4 valid before event", 32'(vld1), m_valid[1]);
        ack0 = la[0]; ack1 = la[1];
        @(posedge clk); #1;
        ack0 = 1'b0; ack1 = 1'b0;
        model_resolve(0, la[0]);
        model_resolve(1, la[1]);
        @(posedge clk); #1;
        check_outs("tick");
    endtask

    task automatic reset_mid();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outs("async rst");
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0, 4'b0, 2'b0, 2'b0);
    endtask

    task automatic seek(input int d, input int c);
        for (int i = 0; i < 12; i++) if (m_col[d] != c) step(4'b0, 4'b0, 2'b0, 2'b0);
        check($sformatf("seek kp%0d col reached", d + 3), 32'(m_col[d]), 32'(c));
    endtask

    task automatic press(input int d, input logic [3:0] pat, input int n, input bit late_last);
        for (int i = 0; i < n; i++) begin
            logic [1:0] la;
            la = 2'b0;
            if (late_last && i == n - 1) la[d] = 1'b1;
            step((d == 0) ? pat : 4'b0, (d == 1) ? pat : 4'b0, 2'b0, la);
        end
    endtask

    logic [3:0] rp[2];
    int         rem[2];
    logic [3:0] rr[2];
    logic [1:0] rea, rla;
    logic [3:0] mv;
    int         sel;

    initial begin
        model_reset();
        @(posedge clk); #1;
        check_outs("por");
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;

        idle(4);                              // free scan, column wrap
        seek(0, 2);
        press(0, 4'b0010, 5, 1'b0);           // row1/col2 -> code 5
        step(4'b0010, 4'b0, 2'b01, 2'b0);     // ack while held
        idle(4);                              // release

        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 4'b0010 : 4'b0, 4'b0, 2'b0, 2'b0);
        press(0, 4'b0010, 5, 1'b0);
        step(4'b0, 4'b0, 2'b0, 2'b0);         // release bounce
        step(4'b0010, 4'b0, 2'b0, 2'b0);
        step(4'b0, 4'b0, 2'b01, 2'b0);
        idle(4);

        seek(0, 0);
        press(0, 4'b0011, 4, 1'b0);           // chord: frozen, no event
        idle(3);

        step(4'b0, 4'b0, 2'b11, 2'b0);
        seek(0, 0);
        press(0, 4'b0001, 4, 1'b0);           // code 0
        idle(4);
        press(0, 4'b0010, 4, 1'b0);           // code 4 -> overflow
        idle(4);
        press(0, 4'b0100, 4, 1'b1);           // ack in event cycle -> code 8
        idle(4);

        seek(0, 1);
        press(0, 4'b1000, 2, 1'b0);           // mid-debounce reset
        reset_mid();
        press(0, 4'b1000, 5, 1'b0);
        idle(1);
        reset_mid();                          // mid-pressed reset
        press(0, 4'b1000, 5, 1'b0);
        idle(4);

        seek(1, 3);
        press(1, 4'b1000, 5, 1'b0);           // row3/col3 on 4x4 -> 15
        idle(5);

        rem[0] = 0; rem[1] = 0; rp[0] = 4'b0; rp[1] = 4'b0;
        for (int t = 0; t < 300; t++) begin
            for (int d = 0; d < 2; d++) begin
                if (rem[d] == 0) begin
                    sel = $urandom_range(0, 9);
                    if (sel < 4) begin
                        rp[d] = 4'b0;
                    end else if (sel < 8) begin
                        rp[d] = 4'b0001 << $urandom_range(0, 3);
                    end else begin
                        do mv = 4'($urandom_range(0, 15)); while ($countones(mv) < 2);
                        rp[d] = mv;
                    end
                    rem[d] = $urandom_range(1, 7);
                end
                rem[d]--;
                rr[d]  = ($urandom_range(0, 7) == 0) ? 4'b0 : rp[d];
                rea[d] = ($urandom_range(0, 3) == 0);
                rla[d] = ($urandom_range(0, 7) == 0);
            end
            step(rr[0], rr[1], rea, rla);
            if (t % 100 == 99) reset_mid();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
